// File: rtl/usb_endp_router.sv
// Routes SIE handshake/data signals to one of N_ENDP endpoint modules selected by the last token,
// and keeps per-endpoint halt state with data-toggle reset pulses.
module usb_endp_router #(
  parameter int N_ENDP       = 3,
  parameter bit STALL_UNUSED = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  usb_reset_i,
  input  logic                  tok_i,
  input  logic [3:0]            endp_i,
  input  logic                  setup_i,
  input  logic                  in_req_i,
  input  logic                  in_ready_i,
  input  logic                  out_ready_i,
  output logic [7:0]            in_data_o,
  output logic                  in_valid_o,
  output logic                  in_zlp_o,
  output logic                  stall_o,
  output logic                  out_nak_o,
  output logic                  in_nak_o,
  input  logic [8*N_ENDP-1:0]   ep_in_data_i,
  input  logic [N_ENDP-1:0]     ep_in_valid_i,
  input  logic [N_ENDP-1:0]     ep_in_zlp_i,
  input  logic [N_ENDP-1:0]     ep_stall_i,
  input  logic [N_ENDP-1:0]     ep_out_nak_i,
  input  logic [N_ENDP-1:0]     ep_in_nak_i,
  output logic [N_ENDP-1:0]     ep_in_req_o,
  output logic [N_ENDP-1:0]     ep_in_ready_o,
  output logic [N_ENDP-1:0]     ep_out_ready_o,
  input  logic                  halt_set_i,
  input  logic                  halt_clr_i,
  input  logic [3:0]            halt_endp_i,
  output logic [N_ENDP-1:0]     halted_o,
  output logic [N_ENDP-1:0]     toggle_rst_o
);

  localparam logic [4:0] N_LIM = 5'(N_ENDP);

  logic [3:0]        endp_q;
  logic [N_ENDP-1:0] halt_q;
  logic [N_ENDP-1:0] toggle_q;
  logic [N_ENDP-1:0] hit;
  logic [N_ENDP-1:0] cmd_hit;
  logic [N_ENDP-1:0] routed;
  logic              sel;
  logic              cmd_ok;
  logic              halted_cur;
  logic              active;

  assign sel    = ({1'b0, endp_q} < N_LIM);
  assign cmd_ok = ({1'b0, halt_endp_i} < N_LIM);

  // hit/cmd_hit are all-zero for out-of-range indices, so no separate guard is needed when indexing.
  always_comb begin
    hit     = '0;
    cmd_hit = '0;
    for (int k = 0; k < N_ENDP; k++) begin
      hit[k]     = (endp_q == 4'(k));
      cmd_hit[k] = (halt_endp_i == 4'(k));
    end
  end

  assign halted_cur = |(hit & halt_q);
  assign active     = sel && !halted_cur;
  assign routed     = hit & {N_ENDP{active}};

  always_comb begin
    in_data_o = '0;
    for (int k = 0; k < N_ENDP; k++) begin
      if (routed[k]) in_data_o = ep_in_data_i[8*k +: 8];
    end
  end

  assign in_valid_o = |(ep_in_valid_i & routed);
  assign in_zlp_o   = |(ep_in_zlp_i & routed);
  assign stall_o    = (|(ep_stall_i & routed)) | (sel & halted_cur) | (!sel & STALL_UNUSED);
  assign out_nak_o  = (|(ep_out_nak_i & routed)) | (!sel & !STALL_UNUSED);
  assign in_nak_o   = (|(ep_in_nak_i & routed)) | (!sel & !STALL_UNUSED);

  assign ep_in_req_o    = routed & {N_ENDP{in_req_i}};
  assign ep_in_ready_o  = routed & {N_ENDP{in_ready_i}};
  assign ep_out_ready_o = routed & {N_ENDP{out_ready_i}};

  assign halted_o     = halt_q;
  assign toggle_rst_o = toggle_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      endp_q <= '0;
    end else if (tok_i) begin
      endp_q <= endp_i;
    end
  end

  // A SETUP on endpoint 0 clears a protocol stall without touching the data toggle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      halt_q   <= '0;
      toggle_q <= '0;
    end else begin
      toggle_q <= '0;
      if (usb_reset_i) begin
        halt_q   <= '0;
        toggle_q <= halt_q;
      end else if (setup_i && endp_q == 4'd0) begin
        halt_q[0] <= 1'b0;
      end else if (halt_set_i && cmd_ok) begin
        halt_q <= halt_q | cmd_hit;
      end else if (halt_clr_i && cmd_ok) begin
        halt_q   <= halt_q & ~cmd_hit;
        toggle_q <= cmd_hit;
      end
    end
  end

endmodule

// File: tb/tb_usb_endp_router.sv
// Bench for usb_endp_router: two instances (STALL_UNUSED=1 and 0) checked every cycle against a model.
module tb_usb_endp_router;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic usb_reset = 0, tok = 0, setup = 0, in_req = 0, in_ready = 0, out_ready = 0;
  logic [3:0] endp = 0, halt_endp = 0;
  logic halt_set = 0, halt_clr = 0;
  logic [8*N-1:0] ep_in_data = '0;
  logic [N-1:0] ep_in_valid = '0, ep_in_zlp = '0, ep_stall = '0, ep_out_nak = '0, ep_in_nak = '0;

  logic [7:0]   a_in_data, b_in_data;
  logic         a_in_valid, a_in_zlp, a_stall, a_out_nak, a_in_nak;
  logic         b_in_valid, b_in_zlp, b_stall, b_out_nak, b_in_nak;
  logic [N-1:0] a_rq, a_ry, a_ory, a_halted, a_tog;
  logic [N-1:0] b_rq, b_ry, b_ory, b_halted, b_tog;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usb_endp_router #(.N_ENDP(N), .STALL_UNUSED(1'b1)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .usb_reset_i(usb_reset), .tok_i(tok), .endp_i(endp),
    .setup_i(setup), .in_req_i(in_req), .in_ready_i(in_ready), .out_ready_i(out_ready),
    .in_data_o(a_in_data), .in_valid_o(a_in_valid), .in_zlp_o(a_in_zlp), .stall_o(a_stall),
    .out_nak_o(a_out_nak), .in_nak_o(a_in_nak), .ep_in_data_i(ep_in_data),
    .ep_in_valid_i(ep_in_valid), .ep_in_zlp_i(ep_in_zlp), .ep_stall_i(ep_stall),
    .ep_out_nak_i(ep_out_nak), .ep_in_nak_i(ep_in_nak), .ep_in_req_o(a_rq),
    .ep_in_ready_o(a_ry), .ep_out_ready_o(a_ory), .halt_set_i(halt_set), .halt_clr_i(halt_clr),
    .halt_endp_i(halt_endp), .halted_o(a_halted), .toggle_rst_o(a_tog));

  usb_endp_router #(.N_ENDP(N), .STALL_UNUSED(1'b0)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .usb_reset_i(usb_reset), .tok_i(tok), .endp_i(endp),
    .setup_i(setup), .in_req_i(in_req), .in_ready_i(in_ready), .out_ready_i(out_ready),
    .in_data_o(b_in_data), .in_valid_o(b_in_valid), .in_zlp_o(b_in_zlp), .stall_o(b_stall),
    .out_nak_o(b_out_nak), .in_nak_o(b_in_nak), .ep_in_data_i(ep_in_data),
    .ep_in_valid_i(ep_in_valid), .ep_in_zlp_i(ep_in_zlp), .ep_stall_i(ep_stall),
    .ep_out_nak_i(ep_out_nak), .ep_in_nak_i(ep_in_nak), .ep_in_req_o(b_rq),
    .ep_in_ready_o(b_ry), .ep_out_ready_o(b_ory), .halt_set_i(halt_set), .halt_clr_i(halt_clr),
    .halt_endp_i(halt_endp), .halted_o(b_halted), .toggle_rst_o(b_tog));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: selected endpoint, halt flags, pending toggle-reset pulse.
  int m_endp = 0;
  bit m_halt [N];
  bit m_tog [N];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_endp = 0;
      for (int k = 0; k < N; k++) begin m_halt[k] = 0; m_tog[k] = 0; end
    end else begin
      for (int k = 0; k < N; k++) m_tog[k] = 0;
      if (usb_reset) begin
        for (int k = 0; k < N; k++) begin m_tog[k] = m_halt[k]; m_halt[k] = 0; end
      end else if (setup && m_endp == 0) begin
        m_halt[0] = 0;
      end else if (halt_set && int'(halt_endp) < N) begin
        m_halt[halt_endp] = 1;
      end else if (halt_clr && int'(halt_endp) < N) begin
        m_halt[halt_endp] = 0;
        m_tog[halt_endp]  = 1;
      end
      if (tok) m_endp = int'(endp);
    end
  end

  task automatic cmp_dut(input string t, input bit unused_stall, input logic [7:0] d,
                         input logic v, input logic z, input logic s, input logic on,
                         input logic inn, input logic [N-1:0] rq, input logic [N-1:0] ry,
                         input logic [N-1:0] ory, input logic [N-1:0] hl, input logic [N-1:0] tg);
    bit sel, hlt;
    logic [N-1:0] onehot, e_h, e_t;
    logic [7:0] e_d;
    logic e_v, e_z, e_s, e_on, e_in;
    sel = (m_endp < N);
    hlt = sel && m_halt[m_endp % N];
    onehot = '0;
    e_d = 8'h00; e_v = 0; e_z = 0; e_s = 0; e_on = 0; e_in = 0;
    if (!sel) begin
      e_s = unused_stall; e_on = !unused_stall; e_in = !unused_stall;
    end else if (hlt) begin
      e_s = 1;
    end else begin
      onehot[m_endp] = 1'b1;
      e_d = ep_in_data[8*m_endp +: 8];
      e_v = ep_in_valid[m_endp]; e_z = ep_in_zlp[m_endp]; e_s = ep_stall[m_endp];
      e_on = ep_out_nak[m_endp]; e_in = ep_in_nak[m_endp];
    end
    for (int k = 0; k < N; k++) begin e_h[k] = m_halt[k]; e_t[k] = m_tog[k]; end
    if (!hlt) chk({t, ".in_data"}, 32'(d), 32'(e_d));
    chk({t, ".in_valid"}, 32'(v), 32'(e_v));
    chk({t, ".in_zlp"}, 32'(z), 32'(e_z));
    chk({t, ".stall"}, 32'(s), 32'(e_s));
    chk({t, ".out_nak"}, 32'(on), 32'(e_on));
    chk({t, ".in_nak"}, 32'(inn), 32'(e_in));
    chk({t, ".ep_in_req"}, 32'(rq), 32'(onehot & {N{in_req}}));
    chk({t, ".ep_in_ready"}, 32'(ry), 32'(onehot & {N{in_ready}}));
    chk({t, ".ep_out_ready"}, 32'(ory), 32'(onehot & {N{out_ready}}));
    chk({t, ".halted"}, 32'(hl), 32'(e_h));
    chk({t, ".toggle_rst"}, 32'(tg), 32'(e_t));
  endtask

  always @(negedge clk) begin
    cmp_dut("a", 1'b1, a_in_data, a_in_valid, a_in_zlp, a_stall, a_out_nak, a_in_nak,
            a_rq, a_ry, a_ory, a_halted, a_tog);
    cmp_dut("b", 1'b0, b_in_data, b_in_valid, b_in_zlp, b_stall, b_out_nak, b_in_nak,
            b_rq, b_ry, b_ory, b_halted, b_tog);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    chk("rst.stall", 32'(a_stall), 0);
    chk("rst.in_valid", 32'(a_in_valid), 0);
    chk("rst.halted", 32'(a_halted), 0);
    chk("rst.toggle", 32'(a_tog), 0);
    chk("rst.b_out_nak", 32'(b_out_nak), 0);
    rstn = 1; tick();

    // Route to endpoint 1
    tok = 1; endp = 4'd1; tick(); tok = 0;
    in_req = 1; ep_in_valid = 3'b010; ep_in_data = 24'h00A500; #1;
    chk("ep1.in_req", 32'(a_rq), 32'h2);
    chk("ep1.in_data", 32'(a_in_data), 32'hA5);
    chk("ep1.in_valid", 32'(a_in_valid), 1);
    tick(); in_req = 0;

    // Halt endpoint 2 and route to it
    halt_set = 1; halt_endp = 4'd2; tick(); halt_set = 0;
    tok = 1; endp = 4'd2; tick(); tok = 0;
    out_ready = 1; #1;
    chk("halt2.stall", 32'(a_stall), 1);
    chk("halt2.out_ready", 32'(a_ory), 0);
    chk("halt2.halted", 32'(a_halted), 32'h4);
    tick(); out_ready = 0;

    halt_clr = 1; halt_endp = 4'd2; tick(); halt_clr = 0;
    chk("clr2.halted", 32'(a_halted), 0);
    chk("clr2.toggle", 32'(a_tog), 32'h4);
    tick();
    chk("clr2.toggle_end", 32'(a_tog), 0);

    // Unimplemented endpoint
    tok = 1; endp = 4'd7; tick(); tok = 0; #1;
    chk("ep7.a_stall", 32'(a_stall), 1);
    chk("ep7.a_out_nak", 32'(a_out_nak), 0);
    chk("ep7.b_stall", 32'(b_stall), 0);
    chk("ep7.b_out_nak", 32'(b_out_nak), 1);
    chk("ep7.b_in_nak", 32'(b_in_nak), 1);
    tick();

    // Halt 0 and 1, SETUP on ep0 clears only 0, bus reset clears rest
    halt_set = 1; halt_endp = 4'd0; tick();
    halt_endp = 4'd1; tick(); halt_set = 0;
    tok = 1; endp = 4'd0; tick(); tok = 0;
    setup = 1; tick(); setup = 0;
    chk("setup.halted", 32'(a_halted), 32'h2);
    usb_reset = 1; tick(); usb_reset = 0;
    chk("busrst.halted", 32'(a_halted), 0);
    chk("busrst.toggle", 32'(a_tog), 32'h2);
    tick();
    chk("busrst.toggle_end", 32'(a_tog), 0);

    // Clear on a non-halted endpoint still resets toggle
    halt_clr = 1; halt_endp = 4'd1; tick(); halt_clr = 0;
    chk("clr_idle.toggle", 32'(a_tog), 32'h2);
    tick();

    // Out-of-range halt commands are ignored
    halt_set = 1; halt_endp = 4'd5; tick(); halt_set = 0;
    chk("oor_set.halted", 32'(a_halted), 0);
    halt_clr = 1; tick(); halt_clr = 0;
    chk("oor_clr.toggle", 32'(a_tog), 0);
    tick();

    // Routing sweep with varied endpoint-side activity
    for (int e = 0; e < 4; e++) begin
      tok = 1; endp = 4'(e); tick(); tok = 0;
      for (int c = 0; c < 6; c++) begin
        in_req = 1'($urandom); in_ready = 1'($urandom); out_ready = 1'($urandom);
        ep_in_data = 24'($urandom);
        ep_in_valid = 3'($urandom); ep_in_zlp = 3'($urandom); ep_stall = 3'($urandom);
        ep_out_nak = 3'($urandom); ep_in_nak = 3'($urandom);
        tick();
      end
    end
    in_req = 0; in_ready = 0; out_ready = 0;
    ep_in_valid = 0; ep_in_zlp = 0; ep_stall = 0; ep_out_nak = 0; ep_in_nak = 0;

    // Set and clear together: set wins, no toggle pulse
    halt_set = 1; halt_clr = 1; halt_endp = 4'd1; tick(); halt_set = 0; halt_clr = 0;
    chk("setclr.halted", 32'(a_halted), 32'h2);
    chk("setclr.toggle", 32'(a_tog), 0);
    #2; rstn = 0; #1;
    chk("async_rst.halted", 32'(a_halted), 0);
    chk("async_rst.b_halted", 32'(b_halted), 0);
    tick(); rstn = 1; tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
